// File: rtl/mc_control_pkg.sv
// mc_control_pkg
//   Shared types and constants for the multi-cycle RV32IM control decoder:
//   ALU operation encodings, opcode values, writeback / PC / branch selects
//   and the sequencer state type.
package mc_control_pkg;

  typedef enum logic [4:0] {
    ALU_AND   = 5'b00000,
    ALU_OR    = 5'b00001,
    ALU_XOR   = 5'b00010,
    ALU_ADD   = 5'b00011,
    ALU_SUB   = 5'b00100,
    ALU_MUL   = 5'b00101,
    ALU_MULH  = 5'b00110,
    ALU_MULHU = 5'b00111,
    ALU_SLL   = 5'b01000,
    ALU_SRL   = 5'b01001,
    ALU_SRA   = 5'b01010,
    ALU_SLT   = 5'b01100,
    ALU_SLTU  = 5'b01101,
    ALU_DIV   = 5'b10000,
    ALU_DIVU  = 5'b10001,
    ALU_REM   = 5'b10010,
    ALU_REMU  = 5'b10011
  } aluop_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_CSRRW  = 3'b001;

  typedef enum logic [1:0] {
    RS_SW  = 2'b00,
    RS_LUI = 2'b01,
    RS_ALU = 2'b10,
    RS_PC4 = 2'b11
  } regsel_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JAL    = 2'b10,
    PC_JALR   = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    BT_ZERO  = 2'b00,
    BT_ONE   = 2'b01,
    BT_NZERO = 2'b10,
    BT_NEVER = 2'b11
  } btype_e;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/mc_decode.sv
// mc_decode
//   Purely combinational instruction decoder. Maps opcode/funct3/funct7/imm
//   to datapath control fields, flags undecodable instructions, and marks
//   instructions that must be sequenced over several cycles.
// Ports:
//   opcode, funct3, funct7, imm   : instruction fields
//   aluop, alusrc, regwrite       : ALU op, immediate select, RF write
//   gpiowe                        : one-hot GPIO channel write enable
//   regsel, pcsrc, btype          : writeback / PC / branch selects
//   illegal                       : instruction cannot be decoded
//   multicycle, is_div            : needs the sequencer; divide-class latency
module mc_decode
  import mc_control_pkg::*;
#(
  parameter int          MUL_CYCLES        = 1,
  parameter int          DIV_EN            = 0,
  parameter int          NUM_GPIO_OUT      = 1,
  parameter logic [11:0] CSR_GPIO_OUT_BASE = 12'hF02,
  parameter logic [11:0] CSR_SW_IN         = 12'hF00
) (
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic [11:0]             imm,
  output logic [4:0]              aluop,
  output logic                    alusrc,
  output logic                    regwrite,
  output logic [NUM_GPIO_OUT-1:0] gpiowe,
  output logic [1:0]              regsel,
  output logic [1:0]              pcsrc,
  output logic [1:0]              btype,
  output logic                    illegal,
  output logic                    multicycle,
  output logic                    is_div
);

  logic [NUM_GPIO_OUT-1:0] gpio_hit;

  // One address comparator per GPIO output channel.
  for (genvar gi = 0; gi < NUM_GPIO_OUT; gi++) begin : g_gpio_hit
    assign gpio_hit[gi] = (imm == CSR_GPIO_OUT_BASE + 12'(gi));
  end

  always_comb begin
    aluop      = ALU_AND;
    alusrc     = 1'b0;
    regwrite   = 1'b0;
    gpiowe     = '0;
    regsel     = RS_ALU;
    pcsrc      = PC_PLUS4;
    btype      = BT_NEVER;
    illegal    = 1'b0;
    multicycle = 1'b0;
    is_div     = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        regwrite = 1'b1;
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000:  aluop = ALU_ADD;
              3'b001:  aluop = ALU_SLL;
              3'b010:  aluop = ALU_SLT;
              3'b011:  aluop = ALU_SLTU;
              3'b100:  aluop = ALU_XOR;
              3'b101:  aluop = ALU_SRL;
              3'b110:  aluop = ALU_OR;
              default: aluop = ALU_AND;
            endcase
          end
          7'b0100000: begin
            case (funct3)
              3'b000:  aluop = ALU_SUB;
              3'b101:  aluop = ALU_SRA;
              default: illegal = 1'b1;
            endcase
          end
          7'b0000001: begin
            case (funct3)
              3'b000: begin aluop = ALU_MUL;   multicycle = (MUL_CYCLES > 1); end
              3'b001: begin aluop = ALU_MULH;  multicycle = (MUL_CYCLES > 1); end
              3'b011: begin aluop = ALU_MULHU; multicycle = (MUL_CYCLES > 1); end
              3'b100, 3'b101, 3'b110, 3'b111: begin
                if (DIV_EN != 0) begin
                  // funct3 100..111 map straight onto DIV, DIVU, REM, REMU
                  aluop      = {3'b100, funct3[1:0]};
                  multicycle = 1'b1;
                  is_div     = 1'b1;
                end else begin
                  illegal = 1'b1;
                end
              end
              default: illegal = 1'b1;  // MULHSU is not supported
            endcase
          end
          default: illegal = 1'b1;
        endcase
      end

      OP_ITYPE: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        case (funct3)
          3'b000: aluop = ALU_ADD;
          3'b010: aluop = ALU_SLT;
          3'b011: aluop = ALU_SLTU;
          3'b100: aluop = ALU_XOR;
          3'b110: aluop = ALU_OR;
          3'b111: aluop = ALU_AND;
          3'b001: begin
            if (funct7 == 7'b0000000) aluop = ALU_SLL;
            else                      illegal = 1'b1;
          end
          default: begin  // 3'b101: shift kind selected by funct7
            if      (funct7 == 7'b0000000) aluop = ALU_SRL;
            else if (funct7 == 7'b0100000) aluop = ALU_SRA;
            else                           illegal = 1'b1;
          end
        endcase
      end

      OP_BRANCH: begin
        pcsrc = PC_BRANCH;
        case (funct3)
          3'b000: begin aluop = ALU_SUB;  btype = BT_ZERO;  end
          3'b001: begin aluop = ALU_SUB;  btype = BT_NZERO; end
          3'b100: begin aluop = ALU_SLT;  btype = BT_ONE;   end
          3'b101: begin aluop = ALU_SLT;  btype = BT_ZERO;  end
          3'b110: begin aluop = ALU_SLTU; btype = BT_ONE;   end
          3'b111: begin aluop = ALU_SLTU; btype = BT_ZERO;  end
          default: illegal = 1'b1;
        endcase
      end

      OP_JAL: begin
        regsel   = RS_PC4;
        regwrite = 1'b1;
        pcsrc    = PC_JAL;
      end

      OP_JALR: begin
        regsel   = RS_PC4;
        regwrite = 1'b1;
        pcsrc    = PC_JALR;
      end

      OP_LUI: begin
        regsel   = RS_LUI;
        regwrite = 1'b1;
      end

      OP_SYSTEM: begin
        if (funct3 != F3_CSRRW) begin
          illegal = 1'b1;
        end else if (|gpio_hit) begin
          gpiowe = gpio_hit;
        end else if (imm == CSR_SW_IN) begin
          regsel   = RS_SW;
          regwrite = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end

      default: illegal = 1'b1;
    endcase

    // An illegal instruction must not disturb the datapath: everything
    // except the flag itself falls back to the idle values.
    if (illegal) begin
      aluop      = ALU_AND;
      alusrc     = 1'b0;
      regwrite   = 1'b0;
      gpiowe     = '0;
      regsel     = RS_ALU;
      pcsrc      = PC_PLUS4;
      btype      = BT_NEVER;
      multicycle = 1'b0;
      is_div     = 1'b0;
    end
  end

endmodule

// File: rtl/mc_control.sv
// mc_control
//   Multi-cycle RV32IM control unit. Single-cycle instructions are decoded
//   combinationally; multiply/divide instructions that need more than one
//   cycle are sequenced by a RUN/WAIT FSM that pulses mdu_start, stalls the
//   front end and issues the register write on the final cycle.
// Ports:
//   clk, rst_n                        : clock, synchronous active-low reset
//   instr_valid, opcode, funct3,
//   funct7, imm                       : instruction register fields
//   aluop, alusrc, regwrite, gpiowe,
//   regsel, pcsrc, btype              : datapath control
//   stall, mdu_start, busy, illegal   : sequencing / status
module mc_control
  import mc_control_pkg::*;
#(
  parameter int          MUL_CYCLES        = 1,
  parameter int          DIV_EN            = 0,
  parameter int          DIV_CYCLES        = 8,
  parameter int          NUM_GPIO_OUT      = 1,
  parameter logic [11:0] CSR_GPIO_OUT_BASE = 12'hF02,
  parameter logic [11:0] CSR_SW_IN         = 12'hF00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic [11:0]             imm,
  output logic [4:0]              aluop,
  output logic                    alusrc,
  output logic                    regwrite,
  output logic [NUM_GPIO_OUT-1:0] gpiowe,
  output logic [1:0]              regsel,
  output logic [1:0]              pcsrc,
  output logic [1:0]              btype,
  output logic                    stall,
  output logic                    mdu_start,
  output logic                    busy,
  output logic                    illegal
);

  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  // The acceptance cycle is one of the L cycles and the final (count==0)
  // cycle is another, so the counter is loaded with L-2.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  logic [4:0]              dec_aluop;
  logic                    dec_alusrc;
  logic                    dec_regwrite;
  logic [NUM_GPIO_OUT-1:0] dec_gpiowe;
  logic [1:0]              dec_regsel;
  logic [1:0]              dec_pcsrc;
  logic [1:0]              dec_btype;
  logic                    dec_illegal;
  logic                    dec_multicycle;
  logic                    dec_is_div;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       aluop_q, aluop_d;
  logic [1:0]       regsel_q, regsel_d;

  mc_decode #(
    .MUL_CYCLES       (MUL_CYCLES),
    .DIV_EN           (DIV_EN),
    .NUM_GPIO_OUT     (NUM_GPIO_OUT),
    .CSR_GPIO_OUT_BASE(CSR_GPIO_OUT_BASE),
    .CSR_SW_IN        (CSR_SW_IN)
  ) u_decode (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .aluop     (dec_aluop),
    .alusrc    (dec_alusrc),
    .regwrite  (dec_regwrite),
    .gpiowe    (dec_gpiowe),
    .regsel    (dec_regsel),
    .pcsrc     (dec_pcsrc),
    .btype     (dec_btype),
    .illegal   (dec_illegal),
    .multicycle(dec_multicycle),
    .is_div    (dec_is_div)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      count_q  <= '0;
      aluop_q  <= '0;
      regsel_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      aluop_q  <= aluop_d;
      regsel_q <= regsel_d;
    end
  end

  always_comb begin
    aluop     = ALU_AND;
    alusrc    = 1'b0;
    regwrite  = 1'b0;
    gpiowe    = '0;
    regsel    = RS_ALU;
    pcsrc     = PC_PLUS4;
    btype     = BT_NEVER;
    stall     = 1'b0;
    mdu_start = 1'b0;
    busy      = 1'b0;
    illegal   = 1'b0;
    state_d   = state_q;
    count_d   = count_q;
    aluop_d   = aluop_q;
    regsel_d  = regsel_q;

    case (state_q)
      RUN: begin
        if (instr_valid) begin
          aluop    = dec_aluop;
          alusrc   = dec_alusrc;
          regwrite = dec_regwrite;
          gpiowe   = dec_gpiowe;
          regsel   = dec_regsel;
          pcsrc    = dec_pcsrc;
          btype    = dec_btype;
          illegal  = dec_illegal;
          if (dec_multicycle) begin
            // Result is not ready yet: hold the write back until WAIT ends.
            mdu_start = 1'b1;
            stall     = 1'b1;
            regwrite  = 1'b0;
            state_d   = WAIT;
            count_d   = dec_is_div ? DIV_LOAD : MUL_LOAD;
            aluop_d   = dec_aluop;
            regsel_d  = dec_regsel;
          end
        end
      end
      WAIT: begin
        busy   = 1'b1;
        aluop  = aluop_q;
        regsel = regsel_q;
        if (count_q != '0) begin
          stall   = 1'b1;
          count_d = count_q - CNT_W'(1);
        end else begin
          regwrite = 1'b1;
          state_d  = RUN;
        end
      end
    endcase

    // Reset overrides everything visible, including an in-flight op.
    if (!rst_n) begin
      aluop     = ALU_AND;
      alusrc    = 1'b0;
      regwrite  = 1'b0;
      gpiowe    = '0;
      regsel    = RS_ALU;
      pcsrc     = PC_PLUS4;
      btype     = BT_NEVER;
      stall     = 1'b0;
      mdu_start = 1'b0;
      busy      = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control
//   Directed bench for mc_control. Instance a: MUL_CYCLES=4, DIV_EN=1,
//   DIV_CYCLES=8, NUM_GPIO_OUT=4. Instance b: defaults (single-cycle MUL,
//   divide disabled, one GPIO channel). Both see the same instruction stream.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm;

  logic [4:0] a_aluop, b_aluop;
  logic       a_alusrc, b_alusrc, a_regwrite, b_regwrite;
  logic [3:0] a_gpiowe;
  logic [0:0] b_gpiowe;
  logic [1:0] a_regsel, b_regsel, a_pcsrc, b_pcsrc, a_btype, b_btype;
  logic       a_stall, b_stall, a_start, b_start, a_busy, b_busy, a_ill, b_ill;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mc_control #(.MUL_CYCLES(4), .DIV_EN(1), .DIV_CYCLES(8), .NUM_GPIO_OUT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .aluop(a_aluop), .alusrc(a_alusrc), .regwrite(a_regwrite), .gpiowe(a_gpiowe),
    .regsel(a_regsel), .pcsrc(a_pcsrc), .btype(a_btype), .stall(a_stall),
    .mdu_start(a_start), .busy(a_busy), .illegal(a_ill)
  );

  mc_control dut_b (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .aluop(b_aluop), .alusrc(b_alusrc), .regwrite(b_regwrite), .gpiowe(b_gpiowe),
    .regsel(b_regsel), .pcsrc(b_pcsrc), .btype(b_btype), .stall(b_stall),
    .mdu_start(b_start), .busy(b_busy), .illegal(b_ill)
  );

  // Packed view: {aluop, alusrc, regwrite, gpiowe[3:0], regsel, pcsrc, btype,
  //               stall, mdu_start, busy, illegal}
  logic [20:0] a_bus, b_bus;
  assign a_bus = {a_aluop, a_alusrc, a_regwrite, a_gpiowe, a_regsel, a_pcsrc,
                  a_btype, a_stall, a_start, a_busy, a_ill};
  assign b_bus = {b_aluop, b_alusrc, b_regwrite, 3'b000, b_gpiowe, b_regsel, b_pcsrc,
                  b_btype, b_stall, b_start, b_busy, b_ill};

  function automatic logic [20:0] ex(logic [4:0] a, logic s, logic rw, logic [3:0] g,
                                     logic [1:0] rs, logic [1:0] pc, logic [1:0] bt,
                                     logic st, logic ms, logic bz, logic il);
    return {a, s, rw, g, rs, pc, bt, st, ms, bz, il};
  endfunction

  localparam logic [20:0] DEF = {5'd0, 1'b0, 1'b0, 4'h0, 2'b10, 2'b00, 2'b11,
                                 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end else begin
      $display("ok   %s: %06h", name, act);
    end
  endtask

  task automatic set_instr(input logic v, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [11:0] im);
    instr_valid = v;
    opcode      = op;
    funct3      = f3;
    funct7      = f7;
    imm         = im;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic        v;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] im;
    logic [20:0] exp;
  } vec_t;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, B = 7'b1100011;
  localparam logic [6:0] SYS = 7'b1110011;
  localparam logic [6:0] F7Z = 7'b0000000, F7A = 7'b0100000, F7M = 7'b0000001;

  vec_t vecs[20];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"add",     1, R, 3'b000, F7Z, 12'h000, ex(5'b00011,0,1,4'h0,2'b10,2'b00,2'b11,0,0,0,0)};
    vecs[1]  = '{"sra",     1, R, 3'b101, F7A, 12'h000, ex(5'b01010,0,1,4'h0,2'b10,2'b00,2'b11,0,0,0,0)};
    vecs[2]  = '{"sub",     1, R, 3'b000, F7A, 12'h000, ex(5'b00100,0,1,4'h0,2'b10,2'b00,2'b11,0,0,0,0)};
    vecs[3]  = '{"sltu",    1, R, 3'b011, F7Z, 12'h000, ex(5'b01101,0,1,4'h0,2'b10,2'b00,2'b11,0,0,0,0)};
    vecs[4]  = '{"r_bad7",  1, R, 3'b010, F7A, 12'h000, ex(5'b00000,0,0,4'h0,2'b10,2'b00,2'b11,0,0,0,1)};
    vecs[5]  = '{"mulhsu",  1, R, 3'b010, F7M, 12'h000, ex(5'b00000,0,0,4'h0,2'b10,2'b00,2'b11,0,0,0,1)};
    vecs[6]  = '{"srai",    1, I, 3'b101, F7A, 12'h405, ex(5'b01010,1,1,4'h0,2'b10,2'b00,2'b11,0,0,0,0)};
    vecs[7]  = '{"xori",    1, I, 3'b100, 7'h7F, 12'hFFF, ex(5'b00010,1,1,4'h0,2'b10,2'b00,2'b11,0,0,0,0)};
    vecs[8]  = '{"slli_bad",1, I, 3'b001, F7A, 12'h401, ex(5'b00000,0,0,4'h0,2'b10,2'b00,2'b11,0,0,0,1)};
    vecs[9]  = '{"bne",     1, B, 3'b001, F7Z, 12'h000, ex(5'b00100,0,0,4'h0,2'b10,2'b01,2'b10,0,0,0,0)};
    vecs[10] = '{"bge",     1, B, 3'b101, F7Z, 12'h000, ex(5'b01100,0,0,4'h0,2'b10,2'b01,2'b00,0,0,0,0)};
    vecs[11] = '{"bltu",    1, B, 3'b110, F7Z, 12'h000, ex(5'b01101,0,0,4'h0,2'b10,2'b01,2'b01,0,0,0,0)};
    vecs[12] = '{"br_010",  1, B, 3'b010, F7Z, 12'h000, ex(5'b00000,0,0,4'h0,2'b10,2'b00,2'b11,0,0,0,1)};
    vecs[13] = '{"jal",     1, 7'b1101111, 3'b000, F7Z, 12'h000, ex(5'b00000,0,1,4'h0,2'b11,2'b10,2'b11,0,0,0,0)};
    vecs[14] = '{"jalr",    1, 7'b1100111, 3'b000, F7Z, 12'h000, ex(5'b00000,0,1,4'h0,2'b11,2'b11,2'b11,0,0,0,0)};
    vecs[15] = '{"lui",     1, 7'b0110111, 3'b000, F7Z, 12'h000, ex(5'b00000,0,1,4'h0,2'b01,2'b00,2'b11,0,0,0,0)};
    vecs[16] = '{"csr_f04", 1, SYS, 3'b001, F7Z, 12'hF04, ex(5'b00000,0,0,4'b0100,2'b10,2'b00,2'b11,0,0,0,0)};
    vecs[17] = '{"csr_f00", 1, SYS, 3'b001, F7Z, 12'hF00, ex(5'b00000,0,1,4'h0,2'b00,2'b00,2'b11,0,0,0,0)};
    vecs[18] = '{"csr_f07", 1, SYS, 3'b001, F7Z, 12'hF07, ex(5'b00000,0,0,4'h0,2'b10,2'b00,2'b11,0,0,0,1)};
    vecs[19] = '{"bad_op",  1, 7'b0000000, 3'b000, F7Z, 12'h000, ex(5'b00000,0,0,4'h0,2'b10,2'b00,2'b11,0,0,0,1)};

    // Reset held with a valid add presented: both instances idle.
    rst_n = 1'b0;
    set_instr(1, R, 3'b000, F7Z, 12'h000);
    step(); step();
    check("reset_a", a_bus, DEF);
    check("reset_b", b_bus, DEF);
    step();
    rst_n = 1'b1;

    // instr_valid low in RUN
    set_instr(0, R, 3'b000, F7Z, 12'h000);
    #1 check("invalid_a", a_bus, DEF);

    // Single-cycle decode table on instance a
    for (int i = 0; i < 20; i++) begin
      step();
      set_instr(vecs[i].v, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].im);
      #1 check(vecs[i].name, a_bus, vecs[i].exp);
    end

    // MUL: 4 cycles on a, single cycle on b; inputs changed during WAIT.
    step();
    set_instr(1, R, 3'b000, F7M, 12'h000);
    #1 check("mul_c0_a", a_bus, ex(5'b00101,0,0,4'h0,2'b10,2'b00,2'b11,1,1,0,0));
    check("mul_b", b_bus, ex(5'b00101,0,1,4'h0,2'b10,2'b00,2'b11,0,0,0,0));
    for (int c = 1; c <= 2; c++) begin
      step();
      set_instr(1, B, 3'b001, F7Z, 12'h000);
      #1 check($sformatf("mul_c%0d_a", c), a_bus, ex(5'b00101,0,0,4'h0,2'b10,2'b00,2'b11,1,0,1,0));
    end
    step();
    #1 check("mul_c3_a", a_bus, ex(5'b00101,0,1,4'h0,2'b10,2'b00,2'b11,0,0,1,0));
    step();
    set_instr(1, R, 3'b000, F7Z, 12'h000);
    #1 check("mul_after_a", a_bus, ex(5'b00011,0,1,4'h0,2'b10,2'b00,2'b11,0,0,0,0));

    // DIV: illegal on b (stays RUN), 8-cycle op on a.
    step();
    set_instr(1, R, 3'b100, F7M, 12'h000);
    #1 check("div_b_illegal", b_bus, ex(5'b00000,0,0,4'h0,2'b10,2'b00,2'b11,0,0,0,1));
    check("div_c0_a", a_bus, ex(5'b10000,0,0,4'h0,2'b10,2'b00,2'b11,1,1,0,0));
    step();
    set_instr(0, R, 3'b000, F7Z, 12'h000);
    #1 check("div_b_run", b_bus, DEF);
    check("div_c1_a", a_bus, ex(5'b10000,0,0,4'h0,2'b10,2'b00,2'b11,1,0,1,0));
    for (int c = 2; c <= 6; c++) begin
      step();
      #1 check($sformatf("div_c%0d_a", c), a_bus, ex(5'b10000,0,0,4'h0,2'b10,2'b00,2'b11,1,0,1,0));
    end
    step();
    #1 check("div_c7_a", a_bus, ex(5'b10000,0,1,4'h0,2'b10,2'b00,2'b11,0,0,1,0));
    step();
    #1 check("div_after_a", a_bus, DEF);

    // Reset pulsed in WAIT cycle 1 of a mul: abandoned, no regwrite later.
    step();
    set_instr(1, R, 3'b000, F7M, 12'h000);
    #1 check("rstw_c0_a", a_bus, ex(5'b00101,0,0,4'h0,2'b10,2'b00,2'b11,1,1,0,0));
    step();
    rst_n = 1'b0;
    set_instr(0, R, 3'b000, F7Z, 12'h000);
    #1 check("rstw_c1_a", a_bus, DEF);
    step();
    rst_n = 1'b1;
    for (int c = 2; c <= 5; c++) begin
      #1 check($sformatf("rstw_c%0d_a", c), a_bus, DEF);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle successor to the single-cycle RV32IM control decoder.
- Decodes opcode/funct3/funct7/imm into datapath control, as before.
- New: sequences multi-cycle multiply/divide ops through a small FSM with stall and start handshake.
- New: parametrised GPIO output channel count, bne support, and an illegal-instruction flag.
- Sits between the instruction register and the datapath/PC logic.

Parameters:
- MUL_CYCLES, 1, total cycles for MUL/MULH/MULHU, range 1..16; 1 means single-cycle.
- DIV_EN, 0, 1 enables DIV/DIVU/REM/REMU; 0 makes them illegal.
- DIV_CYCLES, 8, total cycles for divide/remainder ops, range 2..32.
- NUM_GPIO_OUT, 1, number of GPIO output channels, range 1..8.
- CSR_GPIO_OUT_BASE, 12'hF02, CSR address of GPIO output channel 0; channel k is at BASE+k.
- CSR_SW_IN, 12'hF00, CSR address of the switch input.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- instr_valid  in  1  instruction fields valid this cycle.
- opcode  in  7  instruction opcode.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- imm  in  12  I-immediate / CSR address.
- aluop  out  5  ALU operation.
- alusrc  out  1  1 selects the immediate operand.
- regwrite  out  1  register file write enable.
- gpiowe  out  NUM_GPIO_OUT  one-hot GPIO channel write enable.
- regsel  out  2  writeback select: 00 switches, 01 lui, 10 ALU, 11 PC+4.
- pcsrc  out  2  00 PC+4, 01 branch, 10 jal, 11 jalr.
- btype  out  2  branch condition: 0 ALU result==0, 1 ALU result==1, 2 ALU result!=0, 3 never.
- stall  out  1  hold PC and instruction register.
- mdu_start  out  1  one-cycle pulse starting the multiply/divide unit.
- busy  out  1  FSM is in WAIT.
- illegal  out  1  undecodable instruction.

Behaviour:
- Defaults / reset:
  - Defaults: aluop 0, alusrc 0, regwrite 0, gpiowe 0, regsel 2'b10, pcsrc 0, btype 2'b11, stall 0, mdu_start 0, busy 0, illegal 0.
  - While rst_n is low, all outputs are forced to defaults.
  - At the rising clk edge with rst_n low: state <= RUN, count <= 0, latched fields cleared.
- instr_valid=0 in RUN: all outputs at defaults.
- aluop encoding: AND 00000, OR 00001, XOR 00010, ADD 00011, SUB 00100, MUL 00101, MULH 00110, MULHU 00111, SLL 01000, SRL 01001, SRA 01010, SLT 01100, SLTU 01101, DIV 10000, DIVU 10001, REM 10010, REMU 10011.
- R-type (0110011) and I-type (0010011):
  - Decode per the encodings above; alusrc=1 for I-type.
  - SRA/SRAI require funct7=0100000; SLLI/SRLI require funct7=0000000.
  - Any unlisted funct combination asserts illegal.
- Branch (1100011), pcsrc=01, regwrite=0:
  - beq: SUB, btype 0.
  - bne: SUB, btype 2.
  - blt: SLT, btype 1.
  - bge: SLT, btype 0.
  - bltu: SLTU, btype 1.
  - bgeu: SLTU, btype 0.
  - funct3 010/011 are illegal.
- jal: regsel 11, regwrite 1, pcsrc 10.
- jalr: regsel 11, regwrite 1, pcsrc 11.
- lui: regsel 01, regwrite 1.
- CSRRW (1110011):
  - imm == BASE+k with k<NUM_GPIO_OUT: gpiowe[k]=1, regwrite 0.
  - imm == CSR_SW_IN: regsel 00, regwrite 1.
  - Any other address asserts illegal.
- Unknown opcode: illegal=1; the cycle behaves like instr_valid=0 otherwise.
  - No state change; illegal is combinational and high only in that cycle.
- FSM states: RUN, WAIT.
- Single-cycle ops in RUN: outputs are combinational from the inputs in the same cycle; stall=0.
- Multi-cycle op (MUL* when MUL_CYCLES>1; DIV*/REM* when DIV_EN=1) accepted in RUN, latency L = MUL_CYCLES or DIV_CYCLES:
  - Cycle 0: mdu_start=1, stall=1, regwrite=0; latch aluop and regsel; count <= L-2; next state WAIT.
  - In WAIT: outputs come from the latched values; busy=1, instruction inputs are ignored.
    - count!=0: stall=1, regwrite=0, count decrements.
    - count==0: stall=0, regwrite=1, next state RUN.
  - Net effect: regwrite occurs exactly L-1 cycles after acceptance; stall is high for L-1 cycles.
- Reset asserted during WAIT: the operation is abandoned and no regwrite issues.
- count width is $clog2(max(MUL_CYCLES, DIV_CYCLES)), minimum 1 bit.

Decomposition:
- Package mc_control_pkg holds:
  - aluop_e (5-bit enum of the encodings above);
  - opcode localparams;
  - regsel_e, pcsrc_e, btype_e;
  - state_e {RUN, WAIT}.
- One sub-module, mc_decode: purely combinational opcode/funct/imm to control fields plus illegal and a multicycle flag.
- mc_control wraps mc_decode with the FSM, counter and latches.

Test Plan:
- Reset: hold rst_n=0 with an add instruction presented and instr_valid=1 -> all outputs at defaults, including regsel 2'b10 and btype 2'b11.
- add then sra (funct7=0100000, funct3=101, opcode 0110011) -> aluop 00011, then 01010; regwrite=1 and stall=0 both cycles.
- MUL_CYCLES=4, issue mul -> cycle 0: mdu_start=1, stall=1; cycles 1-2: stall=1, busy=1, regwrite=0; cycle 3: regwrite=1, aluop 00101, stall=0.
- DIV_EN=0, issue div (funct7=0000001, funct3=100) -> illegal=1, regwrite=0, state stays RUN. DIV_EN=1, DIV_CYCLES=8 -> regwrite exactly 7 cycles after acceptance.
- NUM_GPIO_OUT=4, CSRRW to imm 12'hF04 -> gpiowe=4'b0100; to 12'hF00 -> regsel 00, regwrite 1; to 12'hF07 -> illegal=1.
- bne -> aluop 00100, btype 2, pcsrc 01. Reset pulsed at WAIT cycle 1 of a MUL_CYCLES=4 mul -> no regwrite, busy=0 afterwards.
